imem_loader: RTL

Write-side counterpart of the instruction ROM: receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Writes the words into the instruction memory write port at consecutive word addresses. Holds the CPU (PC and register file) via cpu_hold until the load completes. Sits between the host/debug byte source and the instruction memory.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/imem_loader_word_assembler.sv | 34 +++
 rtl/imem_loader.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side types and sizes for the instruction memory path.
// No logic; constants and types only.
// Consumers import with cpu_pkg::*.
package cpu_pkg;

    localparam int XLEN        = 32;
    localparam int IMEM_DEPTH  = 32;
    localparam int IMEM_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs incoming bytes little-endian into a 32-bit lane register.
// Latency: a byte is visible in its lane the cycle after byte_fire.
// Backpressure: none of its own; the caller gates byte_fire.
module word_assembler
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       byte_fire,
    input  logic [7:0] byte_data,
    output word_t      word,
    output logic       last_byte
);

    logic [1:0] byte_idx;
    word_t      lanes;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx <= 2'd0;
            lanes    <= '0;
        end else if (clear) begin
            byte_idx <= 2'd0;
        end else if (byte_fire) begin
            lanes[{byte_idx, 3'b000} +: 8] <= byte_data;
            byte_idx                       <= byte_idx + 2'd1;
        end
    end

    assign word      = lanes;
    assign last_byte = (byte_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-wise program into instruction memory, holding the CPU meanwhile.
// Latency: start -> RECV next cycle; one word written per 4 byte beats + 1 write cycle.
// Backpressure: byte_ready drops during WRITE/DONE/IDLE; byte_valid may stall indefinitely.
module imem_loader #(
    parameter int DEPTH  = cpu_pkg::IMEM_DEPTH,
    parameter int ADDR_W = cpu_pkg::IMEM_ADDR_W,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    import cpu_pkg::*;

    loader_state_t     state;
    loader_state_t     state_nxt;
    logic [ADDR_W:0]   num_words_q;
    logic [ADDR_W-1:0] word_addr;
    logic [XLEN-1:0]   asm_word;
    logic [XLEN-1:0]   wdata_nxt;
    logic              asm_last;
    logic              byte_fire;
    logic              count_ok;
    logic              accept;
    logic              reject;
    logic              last_word;
    logic              word_fire;

    assign count_ok  = (num_words != '0) && (num_words <= (ADDR_W+1)'(DEPTH));
    assign accept    = (state == IDLE) && start && count_ok;
    assign reject    = (state == IDLE) && start && !count_ok;
    assign byte_fire = byte_valid && byte_ready;
    assign word_fire = byte_fire && asm_last;
    assign last_word = ({1'b0, word_addr} == (num_words_q - 1'b1));

    word_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (accept),
        .byte_fire (byte_fire),
        .byte_data (byte_data),
        .word      (asm_word),
        .last_byte (asm_last)
    );

    // The top lane is still in flight on the completing beat, so merge it here.
    always_comb begin
        wdata_nxt              = asm_word;
        wdata_nxt[XLEN-1 -: 8] = byte_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RECV;
            RECV:    if (word_fire) state_nxt = WRITE;
            WRITE:   state_nxt = last_word ? DONE : RECV;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = (state == RECV);
        cpu_hold   = (state != IDLE);
        busy       = (state != IDLE);
        done       = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num_words_q <= '0;
            word_addr   <= '0;
            error       <= 1'b0;
        end else begin
            if (accept) begin
                num_words_q <= num_words;
                word_addr   <= '0;
                error       <= 1'b0;
            end else if (reject) begin
                error <= 1'b1;
            end
            if ((state == WRITE) && !last_word) begin
                word_addr <= word_addr + 1'b1;
            end
        end
    end

    // Write port registered so strobe, address and data move together in WRITE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= word_fire;
            if (word_fire) begin
                mem_addr  <= word_addr;
                mem_wdata <= wdata_nxt;
            end
        end
    end

endmodule
